// File: rtl/vga_pkg.sv
// Shared constants and types for the VGA text-mode buffer.
package vga_pkg;

    localparam int unsigned VGA_AW = 11;
    localparam int unsigned VGA_DW = 8;

    localparam logic [7:0] ATTR_DEFAULT = 8'h07;
    localparam logic [7:0] CHAR_BLANK   = 8'h20;

    typedef enum logic {
        ST_FILL = 1'b0,
        ST_IDLE = 1'b1
    } vga_state_e;

endpackage

// File: rtl/vga_text_buf_dpram.sv
// Two-port synchronous RAM, read-first on both ports.
// Port A is read/write, port B is read-only; read registers clear on reset.
module vga_text_buf_dpram
    import vga_pkg::*;
#(
    parameter int unsigned AW = VGA_AW,
    parameter int unsigned DW = VGA_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          a_en,
    input  logic          a_we,
    input  logic [AW-1:0] a_addr,
    input  logic [DW-1:0] a_wdata,
    output logic [DW-1:0] a_rdata,
    input  logic          b_en,
    input  logic [AW-1:0] b_addr,
    output logic [DW-1:0] b_rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] a_rdata_q, a_rdata_d;
    logic [DW-1:0] b_rdata_q, b_rdata_d;

    // Read data holds unless its port is enabled.
    always_comb begin
        a_rdata_d = a_rdata_q;
        b_rdata_d = b_rdata_q;
        if (a_en) begin
            a_rdata_d = mem_q[a_addr];
        end
        if (b_en) begin
            b_rdata_d = mem_q[b_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (a_en && a_we) begin
            mem_q[a_addr] <= a_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    assign a_rdata = a_rdata_q;
    assign b_rdata = b_rdata_q;

endmodule

// File: rtl/vga_text_buf.sv
// Text-mode buffer: CPU port with ack, fixed-latency video port, and a
// fill engine that sweeps the whole store after reset and on request.
module vga_text_buf
    import vga_pkg::*;
#(
    parameter int unsigned   AW       = VGA_AW,
    parameter int unsigned   DW       = VGA_DW,
    parameter logic [DW-1:0] INIT_VAL = DW'(ATTR_DEFAULT)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cpu_cs,
    input  logic          cpu_we,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_ack,
    input  logic          vid_en,
    input  logic [AW-1:0] vid_addr,
    output logic [DW-1:0] vid_rdata,
    input  logic          fill_req,
    input  logic [DW-1:0] fill_val,
    output logic          busy
);

    localparam logic [AW-1:0] PTR_LAST = '1;

    vga_state_e    state_q, state_d;
    logic [AW-1:0] fill_ptr_q, fill_ptr_d;
    logic [DW-1:0] fill_data_q, fill_data_d;
    logic          ack_q, ack_d;

    logic          a_en_c;
    logic          a_we_c;
    logic [AW-1:0] a_addr_c;
    logic [DW-1:0] a_wdata_c;

    // Next state and port-A arbitration: fill owns the port, else the CPU.
    always_comb begin
        state_d     = state_q;
        fill_ptr_d  = fill_ptr_q;
        fill_data_d = fill_data_q;
        ack_d       = 1'b0;
        a_en_c      = 1'b0;
        a_we_c      = 1'b0;
        a_addr_c    = cpu_addr;
        a_wdata_c   = cpu_wdata;

        case (state_q)
            ST_FILL: begin
                a_en_c     = 1'b1;
                a_we_c     = 1'b1;
                a_addr_c   = fill_ptr_q;
                a_wdata_c  = fill_data_q;
                fill_ptr_d = fill_ptr_q + AW'(1);
                if (fill_ptr_q == PTR_LAST) begin
                    state_d = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (fill_req) begin
                    state_d     = ST_FILL;
                    fill_ptr_d  = '0;
                    fill_data_d = fill_val;
                end else if (cpu_cs) begin
                    a_en_c = 1'b1;
                    a_we_c = cpu_we;
                    ack_d  = 1'b1;
                end
            end
            default: begin
                state_d = ST_FILL;
            end
        endcase

        // Nothing touches the array while reset is held.
        if (rst) begin
            a_en_c = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_FILL;
            fill_ptr_q  <= '0;
            fill_data_q <= INIT_VAL;
            ack_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            fill_ptr_q  <= fill_ptr_d;
            fill_data_q <= fill_data_d;
            ack_q       <= ack_d;
        end
    end

    vga_text_buf_dpram #(
        .AW(AW),
        .DW(DW)
    ) u_dpram (
        .clk     (clk),
        .rst     (rst),
        .a_en    (a_en_c),
        .a_we    (a_we_c),
        .a_addr  (a_addr_c),
        .a_wdata (a_wdata_c),
        .a_rdata (cpu_rdata),
        .b_en    (vid_en),
        .b_addr  (vid_addr),
        .b_rdata (vid_rdata)
    );

    assign cpu_ack = ack_q;
    assign busy    = (state_q == ST_FILL);

endmodule

// File: tb/tb_vga_text_buf.sv
// Self-checking bench for vga_text_buf (AW=4, DW=8) against an array model.
module tb_vga_text_buf;

    localparam int AW    = 4;
    localparam int DW    = 8;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          cpu_cs;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_ack;
    logic          vid_en;
    logic [AW-1:0] vid_addr;
    logic [DW-1:0] vid_rdata;
    logic          fill_req;
    logic [DW-1:0] fill_val;
    logic          busy;

    int total = 0;
    int bad   = 0;

    logic [DW-1:0] model [DEPTH];
    logic [DW-1:0] last_vid;

    vga_text_buf #(
        .AW(AW),
        .DW(DW),
        .INIT_VAL(8'h07)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .cpu_cs    (cpu_cs),
        .cpu_we    (cpu_we),
        .cpu_addr  (cpu_addr),
        .cpu_wdata (cpu_wdata),
        .cpu_rdata (cpu_rdata),
        .cpu_ack   (cpu_ack),
        .vid_en    (vid_en),
        .vid_addr  (vid_addr),
        .vid_rdata (vid_rdata),
        .fill_req  (fill_req),
        .fill_val  (fill_val),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(negedge clk);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_fill(input logic [DW-1:0] v);
        for (int i = 0; i < DEPTH; i++) model[i] = v;
    endtask

    // Counts cycles until busy drops, also counting any ack seen meanwhile.
    task automatic wait_fill(output int n, output int acks);
        n = 0;
        acks = 0;
        while (busy === 1'b1 && n < 100) begin
            tick;
            n++;
            if (cpu_ack !== 1'b0) acks++;
        end
    endtask

    // One CPU access held until ack; checks latency, read-first data and ack width.
    task automatic cpu_xfer(input logic we, input logic [AW-1:0] addr,
                            input logic [DW-1:0] wdata, input string tag, input int lat);
        int n;
        cpu_cs = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = wdata;
        n = 0;
        do begin
            tick;
            n++;
        end while (cpu_ack !== 1'b1 && n < 50);
        check({tag, "_lat"}, n, lat);
        check({tag, "_data"}, cpu_rdata, model[addr]);
        if (we) model[addr] = wdata;
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
        tick;
        check({tag, "_ack_pulse"}, cpu_ack, 0);
    endtask

    initial begin
        int n;
        int acks;
        logic [DW-1:0] old [DEPTH];
        logic [DW-1:0] exp_v;

        rst = 1'b1;
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
        cpu_addr = '0;
        cpu_wdata = '0;
        vid_en = 1'b0;
        vid_addr = '0;
        fill_req = 1'b0;
        fill_val = '0;
        tick;
        tick;
        check("rst_busy", busy, 1);
        check("rst_ack", cpu_ack, 0);
        check("rst_cpu_rdata", cpu_rdata, 0);
        check("rst_vid_rdata", vid_rdata, 0);

        // Post-reset fill
        rst = 1'b0;
        wait_fill(n, acks);
        check("init_fill_len", n, DEPTH);
        check("init_fill_acks", acks, 0);
        model_fill(8'h07);
        for (int a = 0; a < DEPTH; a++) cpu_xfer(1'b0, AW'(a), 8'h00, "init_rd", 1);

        // Write then read back, then back-to-back reads
        cpu_xfer(1'b1, 4'd3, 8'hA5, "wr3", 1);
        cpu_xfer(1'b0, 4'd3, 8'h00, "rd3", 1);
        cpu_cs = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 4'd3;
        tick;
        check("b2b_ack0", cpu_ack, 1);
        check("b2b_data0", cpu_rdata, 8'hA5);
        cpu_addr = 4'd4;
        tick;
        check("b2b_ack1", cpu_ack, 1);
        check("b2b_data1", cpu_rdata, 8'h07);
        cpu_cs = 1'b0;
        tick;
        check("b2b_ack_end", cpu_ack, 0);

        // CPU write colliding with a video read of the same address
        cpu_cs = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 4'd7;
        cpu_wdata = 8'h3C;
        vid_en = 1'b1;
        vid_addr = 4'd7;
        tick;
        check("coll_ack", cpu_ack, 1);
        check("coll_vid_old", vid_rdata, model[7]);
        model[7] = 8'h3C;
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
        tick;
        check("coll_vid_new", vid_rdata, 8'h3C);
        vid_en = 1'b0;
        vid_addr = 4'd0;
        tick;
        tick;
        check("vid_hold", vid_rdata, 8'h3C);
        last_vid = 8'h3C;

        // Random CPU traffic alongside random video reads
        for (int k = 0; k < 40; k++) begin
            cpu_we = 1'($urandom_range(0, 1));
            cpu_addr = AW'($urandom_range(0, DEPTH - 1));
            cpu_wdata = DW'($urandom);
            vid_en = 1'($urandom_range(0, 1));
            vid_addr = AW'($urandom_range(0, DEPTH - 1));
            cpu_cs = 1'b1;
            exp_v = vid_en ? model[vid_addr] : last_vid;
            tick;
            check("rnd_ack", cpu_ack, 1);
            check("rnd_rdata", cpu_rdata, model[cpu_addr]);
            check("rnd_vid", vid_rdata, exp_v);
            last_vid = exp_v;
            if (cpu_we) model[cpu_addr] = cpu_wdata;
            cpu_cs = 1'b0;
            vid_en = 1'b0;
            if ($urandom_range(0, 2) == 0) begin
                tick;
                check("rnd_idle_ack", cpu_ack, 0);
            end
        end
        for (int a = 0; a < DEPTH; a++) cpu_xfer(1'b0, AW'(a), 8'h00, "rnd_sweep", 1);

        // Command fill with video reads racing the sweep and an ignored second request
        for (int i = 0; i < DEPTH; i++) old[i] = model[i];
        fill_req = 1'b1;
        fill_val = 8'h1F;
        tick;
        fill_req = 1'b0;
        check("cmd_busy_rise", busy, 1);
        for (int i = 0; i < DEPTH; i++) begin
            vid_en = 1'b1;
            vid_addr = AW'($urandom_range(0, DEPTH - 1));
            if (i == 5) begin
                fill_req = 1'b1;
                fill_val = 8'h55;
            end
            exp_v = (int'(vid_addr) < i) ? 8'h1F : old[vid_addr];
            tick;
            fill_req = 1'b0;
            check("cmd_vid", vid_rdata, exp_v);
            check("cmd_busy", busy, (i < DEPTH - 1) ? 1 : 0);
        end
        vid_en = 1'b0;
        model_fill(8'h1F);
        for (int a = 0; a < DEPTH; a++) cpu_xfer(1'b0, AW'(a), 8'h00, "cmd_rd", 1);

        // Fill request wins over a simultaneous CPU write, which then waits
        cpu_cs = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 4'd2;
        cpu_wdata = 8'h99;
        fill_req = 1'b1;
        fill_val = 8'h20;
        tick;
        fill_req = 1'b0;
        n = 1;
        while (cpu_ack !== 1'b1 && n < 50) begin
            tick;
            n++;
        end
        check("prio_lat", n, 18);
        check("prio_old", cpu_rdata, 8'h20);
        model_fill(8'h20);
        model[2] = 8'h99;
        cpu_cs = 1'b0;
        cpu_we = 1'b0;
        tick;
        cpu_xfer(1'b0, 4'd2, 8'h00, "prio_rd2", 1);
        cpu_xfer(1'b0, 4'd9, 8'h00, "prio_rd9", 1);

        // Reset in the middle of a command fill
        fill_req = 1'b1;
        fill_val = 8'h33;
        tick;
        fill_req = 1'b0;
        for (int i = 0; i < 9; i++) tick;
        rst = 1'b1;
        tick;
        check("midfill_rst_busy", busy, 1);
        check("midfill_rst_ack", cpu_ack, 0);
        check("midfill_rst_rdata", cpu_rdata, 0);
        rst = 1'b0;
        wait_fill(n, acks);
        check("midfill_len", n, DEPTH);
        check("midfill_acks", acks, 0);
        model_fill(8'h07);
        for (int a = 0; a < DEPTH; a++) cpu_xfer(1'b0, AW'(a), 8'h00, "midfill_rd", 1);

        // Reset over an in-flight access, then a read stalled by the fill
        cpu_xfer(1'b1, 4'd5, 8'hE1, "pre_stall_wr", 1);
        cpu_cs = 1'b1;
        cpu_we = 1'b0;
        cpu_addr = 4'd1;
        rst = 1'b1;
        tick;
        check("acc_rst_ack", cpu_ack, 0);
        check("acc_rst_rdata", cpu_rdata, 0);
        rst = 1'b0;
        model_fill(8'h07);
        cpu_xfer(1'b0, 4'd5, 8'h00, "stall", DEPTH + 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
